sum_threshold_node: RTL

//  Destination end of the PE partial-sum stream: receives 8-bit psum packets addressed to this node.
//  Per time step it adds NUM_PSUM psums to a membrane potential, compares against THRESHOLD and emits one spike packet.

---
 rtl/sum_threshold_node.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sum_threshold_node.sv
// Sum-and-threshold node: accumulates NUM_PSUM psums per time step into a membrane potential and emits one spike packet per step.
// Latency: the edge that accepts the last psum enters FIRE; the next edge raises out_valid, and out_valid then holds until out_ready.
// Backpressure: in_ready is low outside ACCUM, so psums offered during FIRE/SEND wait upstream; out_data is held stable until accepted.
module sum_threshold_node #(
  parameter int         WIDTH     = 35,
  parameter logic [3:0] NODE_ADDR = 4'b0011,
  parameter logic [3:0] OUT_ADDR  = 4'b0000,
  parameter int         NUM_PSUM  = 3,
  parameter int         THRESHOLD = 64,
  parameter int         POT_W     = 10,
  parameter int         NUM_STEPS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             misroute,
  output logic             frame_done
);

  typedef enum logic [1:0] {ACCUM, FIRE, SEND} state_t;

  localparam logic [POT_W-1:0] THR       = POT_W'(THRESHOLD);
  localparam logic [2:0]       LAST_PSUM = 3'(NUM_PSUM - 1);
  localparam logic [3:0]       LAST_STEP = 4'(NUM_STEPS - 1);

  state_t           r_state;
  logic [POT_W-1:0] r_pot;
  logic [POT_W-1:0] r_acc;
  logic [2:0]       r_psum_cnt;
  logic [3:0]       r_step;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_misroute;
  logic             r_frame_done;

  logic             w_accept;
  logic             w_for_me;
  logic [7:0]       w_psum;
  logic [POT_W:0]   w_sum;
  logic [POT_W-1:0] w_sat;
  logic             w_spike;
  logic [POT_W-1:0] w_pot_next;
  logic [WIDTH-1:0] w_pkt;
  logic             w_unused;

  // Only dst and psum matter here; src and tag are deliberately ignored.
  assign w_unused = ^{in_data[34:31], in_data[26:8]};

  assign in_ready = (r_state == ACCUM);
  assign w_accept = in_valid && in_ready;
  assign w_for_me = (in_data[30:27] == NODE_ADDR);
  assign w_psum   = in_data[7:0];

  // One extra bit catches overflow so the potential saturates instead of wrapping.
  assign w_sum      = {1'b0, r_pot} + {1'b0, r_acc};
  assign w_sat      = w_sum[POT_W] ? {POT_W{1'b1}} : w_sum[POT_W-1:0];
  assign w_spike    = (w_sat >= THR);
  assign w_pot_next = w_spike ? (w_sat - THR) : w_sat;
  assign w_pkt      = WIDTH'({NODE_ADDR, OUT_ADDR, 3'b010, 12'd0, r_step, 7'd0, w_spike});

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign misroute   = r_misroute;
  assign frame_done = r_frame_done;

  // Accumulate / fire / send state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ACCUM;
      r_pot        <= '0;
      r_acc        <= '0;
      r_psum_cnt   <= '0;
      r_step       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_misroute   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_misroute   <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        ACCUM: begin
          if (w_accept) begin
            if (w_for_me) begin
              r_acc      <= r_acc + POT_W'(w_psum);
              r_psum_cnt <= r_psum_cnt + 3'd1;
              if (r_psum_cnt == LAST_PSUM) begin
                r_state <= FIRE;
              end
            end else begin
              r_misroute <= 1'b1;
            end
          end
        end
        FIRE: begin
          r_pot       <= w_pot_next;
          r_out_data  <= w_pkt;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_psum_cnt  <= '0;
          r_state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ACCUM;
            // Last step of the frame: the potential and the step counter start over.
            if (r_step == LAST_STEP) begin
              r_step       <= '0;
              r_pot        <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_step <= r_step + 4'd1;
            end
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule
